// File: rtl/mmu_ctrl_pkg.sv
// Shared types and width helpers for the MMU tile sequencer.
//   seq_state_t : sequencer FSM states
//   k_width     : width of the k_len port (holds 0..MAX_K)
//   a_width     : width of the operand step index (0..MAX_K-1)
//   c_width     : width of the phase counters (covers K+2*LENGTH)
package mmu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } seq_state_t;

  function automatic int k_width(input int max_k);
    return $clog2(max_k + 1);
  endfunction

  function automatic int a_width(input int max_k);
    return $clog2(max_k);
  endfunction

  function automatic int c_width(input int max_k, input int length);
    return $clog2(max_k + 2 * length);
  endfunction

endpackage

// File: rtl/mmu_lane_mask_gen.sv
// Per-lane diagonal skew mask for the systolic array feed.
//   feed_cnt  in  CW      current feed step (advancing cycles so far)
//   k         in  CW      accumulation depth of the tile
//   enable    in  1       feed is advancing this cycle
//   lane_mask out LENGTH  bit i set while lane i is inside its K-step window
// Lane i carries data on feed steps i .. i+K-1. Purely combinational.
module mmu_lane_mask_gen #(
  parameter int LENGTH = 256,
  parameter int CW     = 11
) (
  input  logic [CW-1:0]     feed_cnt,
  input  logic [CW-1:0]     k,
  input  logic              enable,
  output logic [LENGTH-1:0] lane_mask
);

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    localparam logic [CW-1:0] LANE = CW'(i);
    if (i == 0) begin : g_first
      // Lower bound is trivially met for lane 0.
      assign lane_mask[i] = enable && (feed_cnt < k);
    end else begin : g_rest
      // LANE + k never overflows: CW covers MAX_K + 2*LENGTH.
      assign lane_mask[i] = enable && (feed_cnt >= LANE) && (feed_cnt < LANE + k);
    end
  end

endmodule

// File: rtl/mmu_tile_sequencer.sv
// Sequences one LENGTH x LENGTH tile on the systolic multiply array:
// clear, K skewed accumulation steps, pipeline drain, then done.
//   CLK, SYNC_RST    clock / synchronous active-high reset
//   start, k_len     tile request and its depth (clamped to MAX_K)
//   operand_valid    low during FEED stalls the sequence
//   abort            drop the current tile, back to IDLE
//   busy             CLEAR/FEED/DRAIN
//   mmu_clear        array SYNC_RST pulse
//   mmu_en           array EN
//   rd_en, rd_addr   operand buffer read strobe and step index
//   lane_mask        per-lane data-valid
//   result_valid     PsumOut holds the final tile
//   done             completion pulse
module mmu_tile_sequencer
  import mmu_ctrl_pkg::*;
#(
  parameter  int LENGTH = 256,
  parameter  int MAX_K  = 1024,
  localparam int KW     = k_width(MAX_K),
  localparam int AW     = a_width(MAX_K),
  localparam int CW     = c_width(MAX_K, LENGTH)
) (
  input  logic              CLK,
  input  logic              SYNC_RST,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              operand_valid,
  input  logic              abort,
  output logic              busy,
  output logic              mmu_clear,
  output logic              mmu_en,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  output logic [LENGTH-1:0] lane_mask,
  output logic              result_valid,
  output logic              done
);

  seq_state_t    state;
  logic [KW-1:0] k_reg;
  logic [CW-1:0] feed_cnt;
  logic [CW-1:0] drain_cnt;

  logic [KW-1:0] k_clamp;
  logic [CW-1:0] k_cw;
  logic [CW-1:0] feed_last;
  logic          feed_adv;

  assign k_clamp   = (k_len > KW'(MAX_K)) ? KW'(MAX_K) : k_len;
  assign k_cw      = CW'(k_reg);
  // Last feed step index: K + LENGTH - 2 (K >= 1 whenever FEED is reached).
  assign feed_last = k_cw + CW'(LENGTH) - CW'(2);
  assign feed_adv  = (state == FEED) && operand_valid;

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state     <= IDLE;
      k_reg     <= '0;
      feed_cnt  <= '0;
      drain_cnt <= '0;
    end else if (abort && state != IDLE) begin
      // Abort wins over stall/advance; the tile is dropped without done.
      state     <= IDLE;
      feed_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            k_reg    <= k_clamp;
            feed_cnt <= '0;
            state    <= (k_clamp != '0) ? CLEAR : DONE;
          end
        end
        CLEAR: begin
          feed_cnt <= '0;
          state    <= FEED;
        end
        FEED: begin
          if (operand_valid) begin
            if (feed_cnt == feed_last) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              feed_cnt <= feed_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == CW'(LENGTH - 1)) state <= DONE;
          else drain_cnt <= drain_cnt + CW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state/counters plus operand_valid.
  assign busy         = (state == CLEAR) || (state == FEED) || (state == DRAIN);
  assign mmu_clear    = (state == CLEAR);
  assign mmu_en       = feed_adv || (state == DRAIN);
  assign rd_en        = feed_adv && (feed_cnt < k_cw);
  assign rd_addr      = rd_en ? feed_cnt[AW-1:0] : '0;
  assign result_valid = (state == DONE);
  assign done         = (state == DONE);

  mmu_lane_mask_gen #(
    .LENGTH (LENGTH),
    .CW     (CW)
  ) u_mask (
    .feed_cnt  (feed_cnt),
    .k         (k_cw),
    .enable    (feed_adv),
    .lane_mask (lane_mask)
  );

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Directed bench for mmu_tile_sequencer at LENGTH=4, MAX_K=16.
// Each scenario starts a tile at cycle 0, records every output per cycle,
// then compares the record against hand-derived cycle positions.
module tb_mmu_tile_sequencer;
  localparam int LENGTH = 4;
  localparam int MAX_K  = 16;
  localparam int KW     = 5;
  localparam int AW     = 4;

  logic              CLK = 1'b0;
  logic              SYNC_RST;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              operand_valid;
  logic              abort;
  logic              busy, mmu_clear, mmu_en, rd_en, result_valid, done;
  logic [AW-1:0]     rd_addr;
  logic [LENGTH-1:0] lane_mask;

  always #5 CLK = ~CLK;

  mmu_tile_sequencer #(.LENGTH(LENGTH), .MAX_K(MAX_K)) dut (
    .CLK           (CLK),
    .SYNC_RST      (SYNC_RST),
    .start         (start),
    .k_len         (k_len),
    .operand_valid (operand_valid),
    .abort         (abort),
    .busy          (busy),
    .mmu_clear     (mmu_clear),
    .mmu_en        (mmu_en),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .lane_mask     (lane_mask),
    .result_valid  (result_valid),
    .done          (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle record of the last scenario.
  logic [63:0] en_v, rd_v, clr_v, done_v, rv_v, busy_v;
  logic [LENGTH-1:0] mask_a [64];
  logic [AW-1:0]     addr_a [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    SYNC_RST = 1'b1; start = 1'b0; abort = 1'b0; operand_valid = 1'b1; k_len = '0;
    @(posedge CLK); #1;
    SYNC_RST = 1'b0;
  endtask

  // Start with k at cycle 0; optional stall window, abort, second start
  // and reset cycles (-1 = unused). k_len is scrambled outside start cycles.
  task automatic run(input int k, input int st_lo, input int st_hi, input int ab_c,
                     input int s2_c, input int rst_c, input int ncyc);
    en_v = '0; rd_v = '0; clr_v = '0; done_v = '0; rv_v = '0; busy_v = '0;
    for (int c = 0; c < ncyc; c++) begin
      start         = (c == 0) || (c == s2_c);
      k_len         = start ? KW'(k) : KW'(1);
      operand_valid = !(c >= st_lo && c <= st_hi);
      abort         = (c == ab_c);
      SYNC_RST      = (c == rst_c);
      #2;
      en_v[c]   = mmu_en;
      rd_v[c]   = rd_en;
      clr_v[c]  = mmu_clear;
      done_v[c] = done;
      rv_v[c]   = result_valid;
      busy_v[c] = busy;
      mask_a[c] = lane_mask;
      addr_a[c] = rd_addr;
      @(posedge CLK); #1;
    end
    start = 1'b0; abort = 1'b0; SYNC_RST = 1'b0; operand_valid = 1'b1;
  endtask

  initial begin
    SYNC_RST = 1'b1; start = 1'b0; abort = 1'b0; operand_valid = 1'b1; k_len = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("reset_outputs",
          64'({busy, mmu_clear, mmu_en, rd_en, rd_addr, lane_mask, result_valid, done}), 64'h0);
    SYNC_RST = 1'b0;

    // 1: K=3, no stalls
    do_reset();
    run(3, -1, -1, -1, -1, -1, 16);
    check("t1_clear",  clr_v,  64'h2);
    check("t1_busy",   busy_v, 64'h0FFE);
    check("t1_en",     en_v,   64'h0FFC);
    check("t1_rd",     rd_v,   64'h001C);
    check("t1_addr2",  64'(addr_a[2]), 64'd0);
    check("t1_addr3",  64'(addr_a[3]), 64'd1);
    check("t1_addr4",  64'(addr_a[4]), 64'd2);
    check("t1_mask2",  64'(mask_a[2]), 64'h1);
    check("t1_mask4",  64'(mask_a[4]), 64'h7);
    check("t1_mask5",  64'(mask_a[5]), 64'hE);
    check("t1_mask7",  64'(mask_a[7]), 64'h8);
    check("t1_mask8",  64'(mask_a[8]), 64'h0);
    check("t1_done",   done_v, 64'h1000);
    check("t1_rvalid", rv_v,   64'h1000);

    // 2: K=3, stall at cycles 3-4
    do_reset();
    run(3, 3, 4, -1, -1, -1, 18);
    check("t2_en",    en_v,   64'h3FE4);
    check("t2_rd",    rd_v,   64'h0064);
    check("t2_mask3", 64'(mask_a[3]), 64'h0);
    check("t2_mask4", 64'(mask_a[4]), 64'h0);
    check("t2_addr5", 64'(addr_a[5]), 64'd1);
    check("t2_done",  done_v, 64'h4000);

    // 3: K=0 goes straight to DONE
    do_reset();
    run(0, -1, -1, -1, -1, -1, 6);
    check("t3_done",  done_v, 64'h2);
    check("t3_clear", clr_v,  64'h0);
    check("t3_en",    en_v,   64'h0);
    check("t3_rd",    rd_v,   64'h0);
    check("t3_busy",  busy_v, 64'h0);

    // 4: abort in DRAIN, restart the very next cycle
    do_reset();
    run(3, -1, -1, 9, 10, -1, 21);
    check("t4_busy10",  64'(busy_v[10]), 64'd0);
    check("t4_en10",    64'(en_v[10]),   64'd0);
    check("t4_clear",   clr_v,  64'h802);
    check("t4_no_done", done_v, 64'h0);

    // 5: k_len=20 clamps to 16; start while busy is ignored
    do_reset();
    run(20, -1, -1, -1, 5, -1, 32);
    check("t5_rd",     rd_v,   64'h3FFFC);
    check("t5_addr2",  64'(addr_a[2]),  64'd0);
    check("t5_addr10", 64'(addr_a[10]), 64'd8);
    check("t5_addr17", 64'(addr_a[17]), 64'd15);
    check("t5_clear",  clr_v,  64'h2);
    check("t5_done",   done_v, 64'h2000000);

    // 6: reset mid-FEED, new start afterwards
    do_reset();
    run(3, -1, -1, -1, 6, 4, 21);
    check("t6_out5",
          64'({busy_v[5], en_v[5], rd_v[5], clr_v[5], done_v[5], mask_a[5]}), 64'h0);
    check("t6_clear", clr_v,  64'h82);
    check("t6_done",  done_v, 64'h40000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
